// File: rtl/psram_qspi_writer.sv
`default_nettype none
// ============================================================================
// psram_qspi_writer : QPI (opcode 0x38) write engine streaming bytes from a
//                     valid/ready source into the external PSRAM.
// Rev 1.0
// ============================================================================
module psram_qspi_writer #(
  parameter int         MAX_BURST      = 32,
  parameter int         CE_HIGH_CYCLES = 2,
  parameter logic [7:0] WR_CMD         = 8'h38
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_start,
  input  logic [23:0] wr_addr,
  input  logic [5:0]  wr_len,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  mem_sio_out,
  output logic        mem_sio_oe,
  output logic        mem_ce_n,
  output logic        mem_clk
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  localparam logic [6:0] c_max_len   = 7'(MAX_BURST);
  localparam logic [7:0] c_hold_last = 8'(CE_HIGH_CYCLES - 1);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;     // 0 = phase L (clk low), 1 = phase H
  logic        wait_q,  wait_d;      // in DATA, waiting for the next byte
  logic [2:0]  nib_q,   nib_d;       // nibble index; bit 0 = low nibble in DATA
  logic [31:0] shift_q, shift_d;
  logic [7:0]  byte_q,  byte_d;
  logic [5:0]  rem_q,   rem_d;       // bytes still to be transferred
  logic [7:0]  hold_q,  hold_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic        w_active;
  logic        w_len_bad;
  logic        w_page_bad;
  logic        w_xfer;
  logic [10:0] w_end;

  assign w_active   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign w_end      = {1'b0, wr_addr[9:0]} + {5'b0, wr_len};
  assign w_len_bad  = (wr_len == 6'd0) || ({1'b0, wr_len} > c_max_len);
  assign w_page_bad = (w_end > 11'd1024);
  assign w_xfer     = data_ready & data_valid;

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign mem_ce_n   = ~w_active;
  assign mem_sio_oe = w_active;
  assign mem_clk    = w_active & phase_q;

  always_comb begin
    data_ready = 1'b0;
    if (state_q == S_ADDR && phase_q && nib_q == 3'd5)
      data_ready = 1'b1;
    if (state_q == S_DATA && phase_q && nib_q[0] && rem_q != 6'd0)
      data_ready = 1'b1;
    if (state_q == S_DATA && wait_q)
      data_ready = 1'b1;
  end

  always_comb begin
    mem_sio_out = 4'h0;
    if (state_q == S_CMD || state_q == S_ADDR)
      mem_sio_out = shift_q[31:28];
    else if (state_q == S_DATA)
      mem_sio_out = nib_q[0] ? byte_q[3:0] : byte_q[7:4];
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = wait_q;
    nib_d   = nib_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (w_xfer) begin
      byte_d = data_in;
      rem_d  = rem_q - 6'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          if (w_len_bad || w_page_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = S_CMD;
            phase_d = 1'b0;
            wait_d  = 1'b0;
            nib_d   = 3'd0;
            shift_d = {WR_CMD, wr_addr};
            rem_d   = wr_len;
          end
        end
      end
      S_CMD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          shift_d = {shift_q[27:0], 4'h0};
          if (nib_q == 3'd1) begin
            state_d = S_ADDR;
            nib_d   = 3'd0;
          end else begin
            nib_d = nib_q + 3'd1;
          end
        end
      end
      S_ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          shift_d = {shift_q[27:0], 4'h0};
          if (nib_q == 3'd5) begin
            state_d = S_DATA;
            nib_d   = 3'd0;
            wait_d  = ~data_valid;
          end else begin
            nib_d = nib_q + 3'd1;
          end
        end
      end
      S_DATA: begin
        // A byte latched while waiting gets one fresh phase L before its clock edge.
        if (wait_q) begin
          if (data_valid)
            wait_d = 1'b0;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!nib_q[0]) begin
            nib_d = 3'd1;
          end else if (rem_q == 6'd0) begin
            state_d = S_HOLD;
            hold_d  = 8'd0;
          end else begin
            nib_d  = 3'd0;
            wait_d = ~data_valid;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == c_hold_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      wait_q  <= 1'b0;
      nib_q   <= 3'd0;
      shift_q <= 32'h0;
      byte_q  <= 8'h0;
      rem_q   <= 6'd0;
      hold_q  <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
      nib_q   <= nib_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/psram_qspi_writer.md
Name: psram_qspi_writer

Overview:
- Quad-SPI (QPI-mode) write engine for the external PSRAM; the counterpart of the existing PSRAM read path that fills the video line cache.
- Accepts a start address and length, then streams bytes from a valid/ready source into the PSRAM with the 0x38 quad-write command. This makes the currently unused write-strobe path usable, so the framebuffer can be loaded.
- Drives the SIO bus as separate out/oe signals; the top level muxes them with the reader under an external arbiter.

Parameters:
- MAX_BURST, 32, maximum bytes per transaction; keeps CE# low time under the PSRAM 8 us limit.
- CE_HIGH_CYCLES, 2, minimum sys_clk cycles CE# stays high after a transaction before done/idle.
- WR_CMD, 8'h38, QPI write opcode.

Ports:
- sys_clk  input  1  work clock (60 MHz); all logic on posedge.
- sys_rst_n  input  1  synchronous active-low reset.
- wr_start  input  1  one-cycle request; sampled only in IDLE.
- wr_addr  input  24  PSRAM byte address; captured on accepted wr_start.
- wr_len  input  6  byte count, 1..MAX_BURST; captured with wr_addr.
- data_in  input  8  write byte.
- data_valid  input  1  data_in valid.
- data_ready  output  1  engine accepts data_in this cycle; transfer = valid & ready.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse at the end of a transaction or rejection.
- err  output  1  one-cycle pulse alongside done when the request was rejected.
- mem_sio_out  output  4  SIO drive value.
- mem_sio_oe  output  1  SIO output enable.
- mem_ce_n  output  1  PSRAM chip enable, active low.
- mem_clk  output  1  SPI clock, half of sys_clk while shifting.

Behaviour:
- Reset (any cycle, including mid-transaction): next cycle state=IDLE, mem_ce_n=1, mem_clk=0, mem_sio_oe=0, mem_sio_out=0, data_ready=0, busy=0, done=0, err=0. An aborted write is discarded; no CE-high hold is enforced.
- Nibble timing: each nibble takes 2 cycles.
  - Phase L: mem_clk=0, new nibble driven on mem_sio_out.
  - Phase H: mem_clk=1, nibble held; PSRAM samples on the rising edge.
  - MSB nibble first.
- Request check, in IDLE on wr_start:
  - Reject when wr_len==0, when wr_len>MAX_BURST, or when the burst crosses a 1024-byte page ((wr_addr[9:0]+wr_len) > 1024).
  - Reject response: next cycle done=1 and err=1; the bus is untouched.
  - Otherwise go to CMD.
- States:
  - IDLE: ce_n=1, oe=0, clk=0.
  - CMD: ce_n=0, oe=1; 2 nibbles of WR_CMD.
  - ADDR: 6 nibbles, wr_addr[23:20] first.
  - DATA: 2 nibbles per byte.
  - HOLD: ce_n=1, oe=0, clk=0, for CE_HIGH_CYCLES cycles.
  - Then IDLE with done=1 for one cycle, busy=0.
- Data handshake:
  - data_ready=1 during phase H of the last ADDR nibble and during phase H of each byte's low nibble (when more bytes remain).
  - On transfer, the byte is latched and its high nibble is driven in the following phase L.
- Stall: if data_valid=0 when ready, the engine stays in phase L with clk=0, ce_n=0, oe=1 and data_ready held at 1 until a transfer. No spurious clock edges occur.
- After the low nibble's phase H of the last byte, go to HOLD; data_ready=0.
- Byte counter decrements per transfer; no transfer is accepted beyond wr_len.
- wr_start while busy is ignored; no queueing.
- Unstalled transaction length: ce_n low for exactly 2*(8+2*len) cycles; mem_clk has exactly 8+2*len rising edges.

Test Plan:
- Reset, then idle 10 cycles -> ce_n=1, oe=0, mem_clk=0, busy=0, data_ready=0 throughout.
- addr=0x001234, len=2, data A5,3C always valid -> nibbles at rising edges 3,8,0,0,1,2,3,4,A,5,3,C; ce_n low 24 cycles; done one cycle after the HOLD of 2 cycles; err=0.
- Same request with data_valid dropped for 5 cycles before byte 2 -> mem_clk frozen low during the gap, sequence unchanged, still exactly 12 rising edges.
- len=0, len=33, and addr=0x0003F0 with len=32 (page cross) -> each gives done=1 and err=1 one cycle after start; ce_n never falls.
- Reset asserted during the ADDR phase of a len=4 write -> next cycle ce_n=1, oe=0, clk=0, IDLE; a new len=1 write then completes with the correct 10-nibble sequence.
- wr_start pulsed during busy -> ignored; exactly one done pulse for the original request.
